// File: rtl/jk_pkg.sv
// Shared command encoding and next-state helper for the JK storage cell.
// Latency: n/a (types and pure functions only).
// Backpressure: none.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_cmd_e;

  localparam int TOGGLE_CNT_W = 16;

  function automatic logic jk_next(input jk_cmd_e cmd, input logic q);
    logic nxt;
    nxt = q;
    case (cmd)
      JK_HOLD: nxt = q;
      JK_CLR:  nxt = 1'b0;
      JK_SET:  nxt = 1'b1;
      JK_TOG:  nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_bit.sv
// Single JK storage bit: hold/clear/set/toggle from {j,k}, sync active-low reset to rst_val.
// Latency: 1 cycle from j/k sample to q.
// Backpressure: none; accepts a command every cycle.
module jk_bit
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  input  logic rst_val,
  output logic q
);

  jk_cmd_e cmd;
  logic    q_nxt;

  always_comb begin
    cmd   = jk_cmd_e'({j, k});
    q_nxt = jk_next(cmd, q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= rst_val;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/jk_latch_cell.sv
// WIDTH independent JK bits with complementary outputs; JK_LATCH_TOGGLE_CNT_EN adds toggle_cnt.
// Latency: 1 cycle from j/k to q; qn is combinational from q.
// Backpressure: none; j/k are sampled every rising edge.
module jk_latch_cell
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        j,
  input  logic [WIDTH-1:0]        k,
  output logic [WIDTH-1:0]        q,
  output logic [WIDTH-1:0]        qn
`ifdef JK_LATCH_TOGGLE_CNT_EN
  ,
  output logic [TOGGLE_CNT_W-1:0] toggle_cnt
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit u_bit (
      .clk     (clk),
      .reset   (reset),
      .j       (j[i]),
      .k       (k[i]),
      .rst_val (RESET_VAL[i]),
      .q       (q[i])
    );
  end

  assign qn = ~q;

`ifdef JK_LATCH_TOGGLE_CNT_EN
  logic                    any_tog;
  logic [TOGGLE_CNT_W-1:0] cnt;

  // One count per edge with any toggling bit, not one per toggling bit.
  assign any_tog = |(j & k);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (any_tog) begin
      cnt <= cnt + TOGGLE_CNT_W'(1);
    end
  end

  assign toggle_cnt = cnt;
`endif

endmodule

// File: tb/tb_jk_latch_cell.sv
// Bench for jk_latch_cell: 1-bit and 4-bit instances, table vectors plus scoreboard queue.
module tb_jk_latch_cell;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] j1, k1, q1, qn1;
  logic [3:0] j4, k4, q4, qn4;
`ifdef JK_LATCH_TOGGLE_CNT_EN
  logic [15:0] cnt1, cnt4;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #2 clk = ~clk;

  jk_latch_cell #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .j     (j1),
    .k     (k1),
    .q     (q1),
    .qn    (qn1)
`ifdef JK_LATCH_TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt1)
`endif
  );

  jk_latch_cell #(.WIDTH(4), .RESET_VAL(4'b1010)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .j     (j4),
    .k     (k4),
    .q     (q4),
    .qn    (qn4)
`ifdef JK_LATCH_TOGGLE_CNT_EN
    ,
    .toggle_cnt (cnt4)
`endif
  );

  typedef struct {
    logic        rst;
    logic        j;
    logic        k;
    logic        q;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          w;
    logic [3:0]  q;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.w == 1) begin
      cmp({e.tag, " q"},  {15'd0, q1},  {15'd0, e.q[0]});
      cmp({e.tag, " qn"}, {15'd0, qn1}, {15'd0, ~e.q[0]});
`ifdef JK_LATCH_TOGGLE_CNT_EN
      cmp({e.tag, " cnt"}, cnt1, e.cnt);
`endif
    end else begin
      cmp({e.tag, " q"},  {12'd0, q4},  {12'd0, e.q});
      cmp({e.tag, " qn"}, {12'd0, qn4}, {12'd0, ~e.q});
`ifdef JK_LATCH_TOGGLE_CNT_EN
      cmp({e.tag, " cnt"}, cnt4, e.cnt);
`endif
    end
  endtask

  // Drive one cycle on the chosen instance (the other holds), push expectation, check after edge.
  task automatic apply(input int w, input logic r, input logic [3:0] j, input logic [3:0] k,
                       input logic [3:0] eq, input logic [15:0] ec, input string tag);
    exp_t e;
    reset = r;
    if (w == 1) begin
      j1 = j[0:0]; k1 = k[0:0]; j4 = '0; k4 = '0;
    end else begin
      j1 = '0; k1 = '0; j4 = j; k4 = k;
    end
    e.w = w; e.q = eq; e.cnt = ec; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  vec_t vecs[16];

  initial begin
    reset = 1'b0;
    j1 = '0; k1 = '0; j4 = '0; k4 = '0;

    //            rst   j     k     q     cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd3};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd5};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'd2};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd2};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd2};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'd2};

    for (int i = 0; i < 16; i++) begin
      apply(1, vecs[i].rst, {3'b0, vecs[i].j}, {3'b0, vecs[i].k},
            {3'b0, vecs[i].q}, vecs[i].cnt, $sformatf("w1 vec%0d", i));
    end

    // Four-bit instance: per-bit mixed commands from a non-zero reset value.
    apply(4, 1'b0, 4'b0000, 4'b0000, 4'b1010, 16'd0, "w4 reset");
    apply(4, 1'b1, 4'b0011, 4'b0101, 4'b1011, 16'd1, "w4 mixed1");
    apply(4, 1'b1, 4'b0011, 4'b0101, 4'b1010, 16'd2, "w4 mixed2");
    apply(4, 1'b1, 4'b1111, 4'b1111, 4'b0101, 16'd3, "w4 togall");
    apply(4, 1'b1, 4'b0000, 4'b0000, 4'b0101, 16'd3, "w4 hold");
    apply(4, 1'b0, 4'b1111, 4'b1111, 4'b1010, 16'd0, "w4 rst_mid");
    apply(4, 1'b1, 4'b1100, 4'b0000, 4'b1110, 16'd0, "w4 set_hi");
    apply(4, 1'b1, 4'b0000, 4'b1111, 4'b0000, 16'd0, "w4 clr_all");

`ifdef JK_LATCH_TOGGLE_CNT_EN
    // Counter wrap on the 1-bit instance.
    apply(1, 1'b0, 4'b0, 4'b0, 4'b0, 16'd0, "w1 wrap_rst");
    reset = 1'b1; j1 = 1'b1; k1 = 1'b1; j4 = '0; k4 = '0;
    repeat (65535) @(posedge clk);
    #1;
    cmp("w1 cnt_ffff", cnt1, 16'hFFFF);
    cmp("w1 q_odd", {15'd0, q1}, 16'd1);
    apply(1, 1'b1, 4'b1, 4'b1, 4'b0, 16'd0, "w1 wrap");
`endif

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
